// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants for the four-channel slow-DAC PWM generator: word layout,
// frame geometry and the per-sub-period threshold helper.
package red_pitaya_pwm_pkg;

  localparam int CCW_DEF    = 8;
  localparam int PERIOD_DEF = 156;

  localparam int WORD_W   = 24;
  localparam int BASE_MSB = 23;
  localparam int BASE_LSB = 16;
  localparam int BASE_W   = BASE_MSB - BASE_LSB + 1;
  localparam int DITH_W   = 16;

  localparam int SUBS  = 16;
  localparam int SUB_W = 4;
  localparam int THR_W = BASE_W + 1;

  // Base duty plus the dither bit owned by this sub-period; the extra bit keeps 255+1 exact.
  function automatic logic [THR_W-1:0] pwm_thr(input logic [BASE_W-1:0] base,
                                               input logic [DITH_W-1:0] dith,
                                               input logic [SUB_W-1:0]  sub);
    return {1'b0, base} + {{BASE_W{1'b0}}, dith[sub]};
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac_if.sv
// Configuration words in, PWM pins and frame strobe out; the master side
// belongs to the register block, the slave side to the PWM generator.
interface red_pitaya_pwm_dac_if;
  import red_pitaya_pwm_pkg::*;

  logic [WORD_W-1:0] cfg_a_i;
  logic [WORD_W-1:0] cfg_b_i;
  logic [WORD_W-1:0] cfg_c_i;
  logic [WORD_W-1:0] cfg_d_i;
  logic [3:0]        pwm_o;
  logic              frame_o;

  modport master (
    output cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
    input  pwm_o, frame_o
  );

  modport slave (
    input  cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
    output pwm_o, frame_o
  );

endinterface

// File: rtl/red_pitaya_pwm_ch.sv
// One PWM channel: frame-aligned shadow of the config word, dithered threshold
// and registered compare against the shared period counter.
module red_pitaya_pwm_ch
  import red_pitaya_pwm_pkg::*;
#(
  parameter int CCW = CCW_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] cfg_i,
  input  logic [CCW-1:0]    cnt_i,
  input  logic [SUB_W-1:0]  sub_i,
  output logic              pwm_o
);

  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic              pwm_q, pwm_d;
  logic [THR_W-1:0]  thr;

  always_comb begin
    shadow_d = shadow_q;
    if (load_i) begin
      shadow_d = cfg_i;
    end
    thr   = pwm_thr(shadow_q[BASE_MSB:BASE_LSB], shadow_q[DITH_W-1:0], sub_i);
    // Thresholds at or above PERIOD never lose the compare, which gives full-period saturation.
    pwm_d = (32'(cnt_i) < 32'(thr));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Four-channel dithered PWM for the slow analog outputs: shared period/sub-period
// counters and frame strobe, one red_pitaya_pwm_ch per channel.
module red_pitaya_pwm_dac
  import red_pitaya_pwm_pkg::*;
#(
  parameter int CCW    = CCW_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  red_pitaya_pwm_dac_if.slave  bus
);

  logic [CCW-1:0]   cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             frame_q, frame_d;
  logic             cnt_wrap;
  logic             frame_hit;

  logic [WORD_W-1:0] cfg_w [4];
  logic [3:0]        pwm;

  always_comb begin
    cnt_wrap  = (cnt_q == CCW'(PERIOD - 1));
    frame_hit = cnt_wrap && (sub_q == SUB_W'(SUBS - 1));
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    sub_d     = cnt_wrap ? sub_q + 1'b1 : sub_q;
    frame_d   = frame_hit;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      sub_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      frame_q <= frame_d;
    end
  end

  assign cfg_w[0] = bus.cfg_a_i;
  assign cfg_w[1] = bus.cfg_b_i;
  assign cfg_w[2] = bus.cfg_c_i;
  assign cfg_w[3] = bus.cfg_d_i;

  // Shadows load on the same edge that raises frame_o, so new words apply from cnt=0, sub=0.
  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    red_pitaya_pwm_ch #(
      .CCW (CCW)
    ) u_ch (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .load_i (frame_hit),
      .cfg_i  (cfg_w[ch]),
      .cnt_i  (cnt_q),
      .sub_i  (sub_q),
      .pwm_o  (pwm[ch])
    );
  end

  assign bus.pwm_o   = pwm;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Scoreboard bench for red_pitaya_pwm_dac: stimulus queues hand-computed high
// counts per (frame, sub-period); a monitor measures each period window and compares.
module tb_red_pitaya_pwm_dac;

  localparam int PERIOD = 156;
  localparam int FRAME  = 16 * PERIOD;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  red_pitaya_pwm_dac_if bus ();

  red_pitaya_pwm_dac #(.CCW(8), .PERIOD(PERIOD)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             frame;
    int             sub;
    logic [3:0]     mask;
    logic [3:0][8:0] hi;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // a0 = channel A high clocks in sub 0, ar = in subs 1..15; B/C/D are flat across subs.
  task automatic push_frame(input int f, input int a0, input int ar, input int b,
                            input int c, input int d, input int nsub);
    exp_t e;
    for (int s = 0; s < nsub; s++) begin
      e.frame = f;
      e.sub   = s;
      e.mask  = 4'hF;
      e.hi[0] = 9'((s == 0) ? a0 : ar);
      e.hi[1] = 9'(b);
      e.hi[2] = 9'(c);
      e.hi[3] = 9'(d);
      sb.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  bit synced;
  int frame_n, off, edges, pre_hi;
  int hi_w[4], pul_w[4];
  bit first_w[4], prev_w[4];

  task automatic finish_period(input int f, input int s);
    exp_t e;
    while (sb.size() > 0 && ((sb[0].frame < f) || (sb[0].frame == f && sb[0].sub < s))) begin
      chk(1'b0, "sb_missed_entry", sb[0].frame * 100 + sb[0].sub, f * 100 + s);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].frame == f && sb[0].sub == s) begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (e.mask[c]) begin
          chk(hi_w[c] == int'(e.hi[c]), $sformatf("high_clocks ch%0d f%0d s%0d", c, f, s),
              hi_w[c], int'(e.hi[c]));
          chk(pul_w[c] == ((e.hi[c] != 0) ? 1 : 0), $sformatf("pulse_count ch%0d f%0d s%0d", c, f, s),
              pul_w[c], (e.hi[c] != 0) ? 1 : 0);
          chk(first_w[c] == (e.hi[c] != 0), $sformatf("pulse_start ch%0d f%0d s%0d", c, f, s),
              int'(first_w[c]), (e.hi[c] != 0) ? 1 : 0);
        end
      end
    end
  endtask

  initial begin
    int onext, pos, s;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        synced = 0; frame_n = 0; off = 0; edges = 0; pre_hi = 0;
      end else begin
        edges++;
        if (!synced) begin
          pre_hi += int'(bus.pwm_o != 4'h0);
        end else begin
          onext = off + 1;
          if (onext <= FRAME) begin
            pos = (onext - 1) % PERIOD + 1;
            s   = (onext - 1) / PERIOD;
            for (int c = 0; c < 4; c++) begin
              if (pos == 1) begin
                hi_w[c] = 0; pul_w[c] = 0; prev_w[c] = 0; first_w[c] = bus.pwm_o[c];
              end
              if (bus.pwm_o[c]) hi_w[c]++;
              if (bus.pwm_o[c] && !prev_w[c]) pul_w[c]++;
              prev_w[c] = bus.pwm_o[c];
            end
            if (pos == PERIOD) finish_period(frame_n, s);
          end else if (onext == FRAME + 1) begin
            chk(1'b0, "frame_gap_overrun", onext, FRAME);
          end
          off = onext;
        end
        if (bus.frame_o) begin
          if (!synced) begin
            chk(edges == FRAME, "first_frame_after_reset", edges, FRAME);
            chk(pre_hi == 0, "frame0_all_low", pre_hi, 0);
          end else begin
            chk(off == FRAME, "frame_period", off, FRAME);
          end
          synced = 1;
          frame_n++;
          off = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_frame();
    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      if (bus.frame_o) return;
    end
    chk(1'b0, "frame_timeout", 0, 1);
  endtask

  initial begin
    bus.cfg_a_i = 24'h000000;
    bus.cfg_b_i = 24'h100000;
    bus.cfg_c_i = 24'hC80000;
    bus.cfg_d_i = 24'h9BFFFF;

    repeat (4) @(negedge clk);
    chk(bus.pwm_o == 4'h0, "reset_pwm", int'(bus.pwm_o), 0);
    chk(bus.frame_o == 1'b0, "reset_frame", int'(bus.frame_o), 0);

    // Frame 1 carries the words present at the first boundary.
    push_frame(1, 0, 0, 16, 156, 156, 16);
    #1 rstn = 1'b1;

    wait_frame();
    repeat (1000) @(negedge clk);
    // Mid-frame change: frame 1 keeps old values, frame 2 takes the new ones.
    bus.cfg_a_i = 24'h0A0001;
    bus.cfg_b_i = 24'h200000;
    push_frame(2, 11, 10, 32, 156, 156, 16);

    wait_frame();
    repeat (500) @(negedge clk);
    bus.cfg_a_i = 24'h4E0000;
    push_frame(3, 78, 78, 32, 156, 156, 8);

    wait_frame();
    repeat (10 * PERIOD + 40) @(posedge clk);
    #3;
    chk(bus.pwm_o == 4'b1101, "pre_drop_pwm", int'(bus.pwm_o), 13);
    chk(sb.size() == 0, "sb_drained_before_reset", sb.size(), 0);
    rstn = 1'b0;
    #1;
    chk(bus.pwm_o == 4'h0, "async_reset_pwm", int'(bus.pwm_o), 0);
    chk(bus.frame_o == 1'b0, "async_reset_frame", int'(bus.frame_o), 0);

    repeat (3) @(negedge clk);
    chk(bus.pwm_o == 4'h0, "held_reset_pwm", int'(bus.pwm_o), 0);
    push_frame(1, 78, 78, 32, 156, 156, 16);
    #1 rstn = 1'b1;

    wait_frame();
    wait_frame();
    repeat (3) @(negedge clk);
    chk(sb.size() == 0, "sb_drained_at_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "watchdog");
  end

endmodule
